// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the E-stage multiply/divide sequencer:
//   - MD_* operation codes carried in the E-stage control word
//   - MD_IDLE / MD_RUN sequencer state encodings
//   - small op-class helpers used by the controller
// Optional feature macro: MULDIV_DIV_EN (enables DIV/DIVU support).
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_RUN  = 1'b1;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// -----------------------------------------------------------------------------
// muldiv_core
// Purely combinational arithmetic for the multiply/divide sequencer.
// Ports:
//   a      in  32  rs operand (dividend / multiplicand)
//   b      in  32  rt operand (divisor / multiplier)
//   op     in   3  MD_* operation code
//   result out 64  {hi, lo}: product, or {remainder, quotient}
// Optional feature macro: MULDIV_DIV_EN (divide path present only when defined;
// otherwise DIV/DIVU yield zero and the controller never selects them).
// -----------------------------------------------------------------------------
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [63:0] result
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic        [63:0] prod_s;
    logic        [63:0] prod_u;

    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MULDIV_DIV_EN
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // SV signed / and % truncate toward zero with the remainder taking the
    // dividend's sign, which is exactly the architectural rule.
    assign q_s = $signed(a) / $signed(b);
    assign r_s = $signed(a) % $signed(b);
    assign q_u = a / b;
    assign r_u = a % b;
`endif

    always_comb begin
        result = '0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
`ifdef MULDIV_DIV_EN
            MD_DIV: begin
                if (div_zero)
                    result = {a, 32'hFFFF_FFFF};
                else if (div_ovf)
                    result = {32'd0, 32'h8000_0000};
                else
                    result = {r_s, q_s};
            end
            MD_DIVU: begin
                if (div_zero)
                    result = {a, 32'hFFFF_FFFF};
                else
                    result = {r_u, q_u};
            end
`endif
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// E-stage multi-cycle multiply/divide sequencer owning the HI/LO pair.
// Parameters:
//   MUL_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES  busy cycles for DIV/DIVU   (1..15, ignored without divide)
// Ports:
//   clk    in   1  clock
//   rst    in   1  synchronous active-high reset
//   start  in   1  launch request from the E-stage control word
//   op     in   3  MD_* operation code
//   a      in  32  rs operand (forwarded)
//   b      in  32  rt operand (forwarded)
//   busy   out  1  a multiply/divide is in flight (registered, no path from start)
//   hi     out 32  architectural HI
//   lo     out 32  architectural LO
// Optional feature macro: MULDIV_DIV_EN (DIV/DIVU accepted only when defined).
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
        $error("muldiv_ctrl: MUL_CYCLES must be in 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
        $error("muldiv_ctrl: DIV_CYCLES must be in 1..15");
    end

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
`ifdef MULDIV_DIV_EN
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);
`endif

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [63:0] pend;
    logic [63:0] core_result;

    muldiv_core u_core (
        .a      (a),
        .b      (b),
        .op     (op),
        .result (core_result)
    );

    assign busy = (state == MD_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
            pend  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        if (is_mul_op(op)) begin
                            pend  <= core_result;
                            cnt   <= MUL_LOAD;
                            state <= MD_RUN;
                        end
`ifdef MULDIV_DIV_EN
                        else if (is_div_op(op)) begin
                            pend  <= core_result;
                            cnt   <= DIV_LOAD;
                            state <= MD_RUN;
                        end
`endif
                        else if (op == MD_MTHI) begin
                            hi <= a;
                        end else if (op == MD_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                MD_RUN: begin
                    // Commit on the edge that ends the last busy cycle, so the
                    // new HI/LO appear in the same cycle busy drops.
                    if (cnt == 4'd0) begin
                        {hi, lo} <= pend;
                        state    <= MD_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule
